// File: rtl/fault_campaign_sequencer_if.sv
// fault_campaign_sequencer_if: stimulus/observation bus and result handshake
// between the campaign sequencer (master) and the harness under test (slave).
interface fault_campaign_sequencer_if #(
    parameter int A_W   = 64,
    parameter int B_W   = 64,
    parameter int OBS_W = 128,
    parameter int FID_W = 16
);
    logic [A_W-1:0]   stim_a;
    logic [B_W-1:0]   stim_b;
    logic [FID_W-1:0] fault_id;
    logic             fault_en;
    logic [OBS_W-1:0] obs;
    logic             res_valid;
    logic             res_ready;
    logic [FID_W-1:0] res_fid;
    modport master (output stim_a, stim_b, fault_id, fault_en, res_valid, res_fid,
                    input obs, res_ready);
    modport slave (input stim_a, stim_b, fault_id, fault_en, res_valid, res_fid,
                   output obs, res_ready);
endinterface

// File: rtl/fault_campaign_sequencer.sv
// fault_campaign_sequencer: golden pass then one faulty pass per fault ID, signature compare.
// Optional detected-fault result FIFO enabled by macro FCS_RESULT_FIFO_EN.
module fault_campaign_sequencer #(
    parameter int          A_W        = 64,
    parameter int          B_W        = 64,
    parameter int          OBS_W      = 128,
    parameter int          STEPS      = 256,
    parameter int          FID_W      = 16,
    parameter int          SIG_W      = 32,
    parameter logic [31:0] B_PAT      = 32'h0F_FF_55_AA,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [FID_W-1:0]       batch_start,
    input  logic [FID_W-1:0]       batch_end,
    input  logic                   mode,
    fault_campaign_sequencer_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic                   fault_done,
    output logic                   fault_detected,
    output logic [FID_W-1:0]       detected_cnt
);
    localparam int SW = $clog2(STEPS);
    localparam logic [SIG_W-1:0] POLY = SIG_W'(32'h04C11DB7);
    typedef enum logic [2:0] {IDLE, GOLD, RUN, CMP, FIN} state_e;
    state_e            state_q, state_d;
    logic [SW-1:0]     step_q, step_d, gen_step;
    logic [A_W-1:0]    stim_a_q, stim_a_d;
    logic [B_W-1:0]    stim_b_q, stim_b_d;
    logic [31:0]       lfsr_q, lfsr_d, cur_l, s32;
    logic [SIG_W-1:0]  sig_q, sig_d, gold_q, gold_d, sig_fold, obs_x;
    logic [FID_W-1:0]  fid_q, fid_d, fid_inc, bs_q, be_q, cnt_q;
    logic              mode_q, mode_sel, gen_en, pass_start, stall, last;
    logic [1:0]        quarter;
    logic [7:0]        b_byte;

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        fid_d      = fid_q;
        gold_d     = gold_q;
        sig_d      = sig_q;
        gen_en     = 1'b0;
        pass_start = 1'b0;
        gen_step   = step_q + 1'b1;
        fid_inc    = fid_q + 1'b1;
        last       = step_q == SW'(STEPS - 1);
        case (state_q)
            IDLE: if (start) begin
                state_d    = batch_start >= batch_end ? FIN : GOLD;
                pass_start = batch_start < batch_end;
            end
            GOLD, RUN: begin
                sig_d  = sig_fold;
                step_d = gen_step;
                gen_en = !last;
                if (last) begin
                    state_d    = state_q == GOLD ? RUN : CMP;
                    pass_start = state_q == GOLD;
                    gold_d     = state_q == GOLD ? sig_fold : gold_q;
                    fid_d      = state_q == GOLD ? bs_q : fid_q;
                end
            end
            CMP: if (!stall) begin
                fid_d      = fid_inc;
                state_d    = fid_inc == be_q ? FIN : RUN;
                pass_start = fid_inc != be_q;
            end
            default: state_d = IDLE;
        endcase
        // every pass restarts the signature, the step count and the LFSR seed
        if (pass_start) begin
            sig_d    = '1;
            step_d   = '0;
            gen_en   = 1'b1;
            gen_step = '0;
        end
    end

    always_comb begin
        cur_l    = pass_start ? 32'h1 : lfsr_q;
        s32      = 32'(gen_step);
        quarter  = gen_step[SW-1 -: 2];
        b_byte   = B_PAT[8*quarter +: 8];
        mode_sel = state_q == IDLE ? mode : mode_q;
        stim_a_d = '0;
        stim_b_d = '0;
        for (int j = 0; j < A_W; j++)
            stim_a_d[j] = gen_en & (mode_sel ? cur_l[j%32]
                                             : (quarter == 2'd1) | (quarter[1] & (s32[j%4] ^ j[0])));
        for (int j = 0; j < B_W; j++)
            stim_b_d[j] = gen_en & (mode_sel ? ~cur_l[j%32] : (j < 8) & b_byte[j%8]);
        lfsr_d = gen_en ? (cur_l >> 1) ^ (cur_l[0] ? 32'h80200003 : 32'h0) : lfsr_q;
        obs_x  = '0;
        for (int k = 0; k < OBS_W / SIG_W; k++)
            obs_x = obs_x ^ bus.obs[k*SIG_W +: SIG_W];
        sig_fold = {sig_q[SIG_W-2:0], ^(sig_q & POLY)} ^ obs_x;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            step_q   <= '0;
            stim_a_q <= '0;
            stim_b_q <= '0;
            lfsr_q   <= 32'h1;
            sig_q    <= '1;
            gold_q   <= '1;
            fid_q    <= '0;
            cnt_q    <= '0;
            bs_q     <= '0;
            be_q     <= '0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            stim_a_q <= stim_a_d;
            stim_b_q <= stim_b_d;
            lfsr_q   <= lfsr_d;
            sig_q    <= sig_d;
            gold_q   <= gold_d;
            fid_q    <= fid_d;
            cnt_q    <= cnt_q + FID_W'(fault_detected & ~&cnt_q);
            if (state_q == IDLE && start) begin
                bs_q   <= batch_start;
                be_q   <= batch_end;
                mode_q <= mode;
            end
        end
    end

    assign busy           = state_q != IDLE;
    assign done           = state_q == FIN;
    assign fault_done     = state_q == CMP && !stall;
    assign fault_detected = fault_done && sig_q != gold_q;
    assign detected_cnt   = cnt_q;
    assign bus.stim_a     = stim_a_q;
    assign bus.stim_b     = stim_b_q;
    assign bus.fault_id   = fid_q;
    assign bus.fault_en   = state_q == RUN;

`ifdef FCS_RESULT_FIFO_EN
    localparam int PW = $clog2(FIFO_DEPTH);
    logic [FID_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW:0]      wp_q, rp_q;
    logic             full, pop;
    assign pop           = bus.res_valid && bus.res_ready;
    assign full          = (wp_q - rp_q) == (PW+1)'(FIFO_DEPTH);
    // a pop in the same cycle frees the slot the push needs
    assign stall         = state_q == CMP && sig_q != gold_q && full && !pop;
    assign bus.res_valid = wp_q != rp_q;
    assign bus.res_fid   = bus.res_valid ? mem_q[rp_q[PW-1:0]] : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_q + {{PW{1'b0}}, fault_detected};
            rp_q <= rp_q + {{PW{1'b0}}, pop};
        end
    end
    always_ff @(posedge clk)
        if (fault_detected) mem_q[wp_q[PW-1:0]] <= fid_q;
`else
    localparam int unused_depth = FIFO_DEPTH;
    logic unused_ready;
    assign unused_ready  = bus.res_ready;
    assign stall         = 1'b0;
    assign bus.res_valid = 1'b0;
    assign bus.res_fid   = '0;
`endif
endmodule

// File: doc/fault_campaign_sequencer.md
FAULT_CAMPAIGN_SEQUENCER -- requirements
Module: fault_campaign_sequencer

Interface
REQ-001 The block SHALL have parameter A_W, default 64, meaning width of stimulus operand A.
REQ-002 The block SHALL have parameter B_W, default 64, meaning width of stimulus operand B (B_W >= 8).
REQ-003 The block SHALL have parameter OBS_W, default 128, meaning width of observed DUT output (multiple of SIG_W).
REQ-004 The block SHALL have parameter STEPS, default 256, meaning stimulus steps per pass (power of 2, >= 8).
REQ-005 The block SHALL have parameter FID_W, default 16, meaning fault ID width.
REQ-006 The block SHALL have parameter SIG_W, default 32, meaning signature width.
REQ-007 The block SHALL have parameter B_PAT, default 32'h0F_FF_55_AA, meaning B[7:0] value per quarter (byte q for quarter q).
REQ-008 The block SHALL have parameter FIFO_DEPTH, default 8, meaning result FIFO depth (power of 2).
REQ-009 The block SHALL have ports: clk in 1 clock; rst_n in 1 async active-low reset; start in 1 campaign start pulse; batch_start in FID_W first fault ID; batch_end in FID_W exclusive last fault ID; mode in 1 stimulus mode; stim_a out A_W; stim_b out B_W; fault_id out FID_W; fault_en out 1 (injection enable); obs in OBS_W; busy out 1; done out 1; fault_done out 1; fault_detected out 1; detected_cnt out FID_W; res_valid out 1; res_ready in 1; res_fid out FID_W.
REQ-010 Reset SHALL be asynchronous and active-low on rst_n; all state SHALL be clocked on rising clk.

Function
REQ-011 The FSM SHALL have states IDLE, GOLD, RUN, CMP, FIN.
REQ-012 In IDLE, start=1 SHALL latch batch_start, batch_end and mode. If batch_start >= batch_end, the FSM SHALL go to FIN. Otherwise it SHALL go to GOLD. start SHALL be ignored outside IDLE.
REQ-013 GOLD SHALL run STEPS steps with fault_en=0. The final signature SHALL be stored as golden; the FSM then SHALL enter RUN with fault_id=batch_start.
REQ-014 RUN SHALL run STEPS steps with fault_en=1 and then enter CMP; fault_id SHALL stay constant during a pass.
REQ-015 Step timing: stimulus for step s SHALL be registered at the start of cycle s, and obs SHALL be folded into the signature at the end of the same cycle (combinational DUT, one step per cycle).
REQ-016 Signature: initialised to all-ones at each pass start; sig_next = {sig[SIG_W-2:0], ^(sig & 32'h04C11DB7)} XOR (XOR of all SIG_W-wide slices of obs).
REQ-017 Mode 0, A pattern: A=0 for s < STEPS/4; A=all-ones for s < STEPS/2; afterwards A[j] = s[j mod 4] XOR j[0].
REQ-018 Mode 0, B pattern: B[7:0] = byte (s / (STEPS/4)) of B_PAT; B[B_W-1:8] = 0.
REQ-019 Mode 1 SHALL drive A and B from a 32-bit Galois LFSR (taps 0x80200003, seed 32'h1). The LFSR SHALL be reseeded at every pass start so that every pass sees identical stimulus. A and B SHALL be the LFSR state replicated/truncated to width, with B taking the bitwise inverse.
REQ-020 CMP SHALL last 1 cycle. It SHALL assert fault_done=1 and fault_detected=(sig != golden). On detection, detected_cnt SHALL increment, saturating at all-ones.
REQ-021 After CMP, the FSM SHALL increment fault_id. If fault_id+1 == batch_end it SHALL go to FIN; otherwise it SHALL go to RUN. The fault_id increment SHALL wrap at 2^FID_W with no special case.
REQ-022 FIN SHALL pulse done=1 for one cycle and then return to IDLE. busy=1 in every state except IDLE. Stimulus SHALL be zero in IDLE and FIN.

Reset
REQ-023 rst_n=0 SHALL force the following, immediately, including mid-pass: state IDLE; stim_a=0; stim_b=0; fault_id=0; fault_en=0; busy=0; done=0; fault_done=0; fault_detected=0; detected_cnt=0; signature and golden all-ones; FIFO empty; res_valid=0; res_fid=0.
REQ-024 After reset deassertion, no campaign SHALL resume without a new start.

Configuration
REQ-025 Macro FCS_RESULT_FIFO_EN present: each detected fault_id SHALL be pushed into a FIFO_DEPTH FIFO. The FIFO SHALL present it on res_fid/res_valid, and a pop SHALL occur when res_valid and res_ready are both 1. If the FIFO is full at CMP, the FSM SHALL stall in CMP with fault_done held low until a slot frees. A push and a pop in the same cycle on a full FIFO SHALL proceed without stalling.
REQ-026 Macro FCS_RESULT_FIFO_EN absent: there SHALL be no FIFO and no stall; res_valid SHALL be tied to 0, res_fid to 0, and res_ready SHALL be ignored.

Verification
REQ-027 Scenario 1: batch 0..4, obs tied to 0 -> 1 GOLD + 4 RUN passes; fault_done pulses=4; detected_cnt=0; done pulse after 5*STEPS+4+2 cycles from start.
REQ-028 Scenario 2: batch 0..4, DUT model flips obs[0] when fault_en && fault_id==2 -> fault_detected only on the fault_id=2 CMP; detected_cnt=1; res_fid=2 when FIFO is enabled.
REQ-029 Scenario 3: batch_start=7, batch_end=7 -> FIN next cycle, done=1, detected_cnt=0, fault_en never 1.
REQ-030 Scenario 4: FIFO on, FIFO_DEPTH=2, res_ready=0, all faults detected, batch 0..5 -> FSM stalls in CMP at third detection; raising res_ready resumes; res_fid sequence 0,1,2,3,4.
REQ-031 Scenario 5: mode 0, STEPS=256 -> stim_b[7:0] = AA, 55, FF, 0F at steps 0, 64, 128, 192; stim_a=0 at step 10, all-ones at step 100, stim_a[1:0]=2'b10 at step 128.
REQ-032 Scenario 6: rst_n low at step 37 of a RUN pass -> all outputs at reset values at once; start after release restarts from GOLD with detected_cnt=0.
